periph_bus_ctrl: RTL and testbench
==================================

# periph_bus_ctrl

Two-master, N-slave controller for the board's memory-mapped peripheral bus (valid/ready/wstrb/addr/wdata/rdata). It arbitrates round-robin between the CPU port (m0) and a debug/DMA port (m1). It decodes the address to one peripheral slot, sequences the slave handshake including the post-transfer recovery cycle our GPIO-style slaves need, and completes unmapped or hung accesses with an error pulse.

## Interface
- `NSLAVE`, 4: number of peripheral slots, power of two, 2..16.
- `BASE`, 32'h4000_0000: base of the peripheral window; must be aligned to NSLAVE·2^SLOT_BITS.
- `SLOT_BITS`, 8: log2 bytes per slot (256 B).
- `TIMEOUT`, 255: maximum ACCESS cycles without slave ready; range 1..65535.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `m0_valid`, `m1_valid`  in  1  master request.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write strobes; 0 = read.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid while the matching ready is high.
- `s_valid`  out  NSLAVE  one-hot slave select/request.
- `s_ready`  in  NSLAVE  per-slave ready.
- `s_wstrb`  out  4  shared strobes.
- `s_addr`  out  32  shared address.
- `s_wdata`  out  32  shared write data.
- `s_rdata`  in  32·NSLAVE  slave k occupies bits [32k+31:32k].
- `bus_err`  out  1  one-cycle pulse on decode miss or timeout.

## Operation
- States: IDLE, ACCESS, RESP, GAP.
- IDLE, no request: stay in IDLE.
- IDLE, any master valid: grant by round-robin. If both masters request, the one not granted last wins. After reset, m0 has priority.
  - Latch the granted master's addr, wdata and wstrb into s_addr, s_wdata and s_wstrb.
  - Decode: hit when addr[31:SLOT_BITS+log2(NSLAVE)] equals the same bits of BASE. Slot index is addr[SLOT_BITS +: log2(NSLAVE)].
  - Hit: go to ACCESS. Miss: go to RESP with error flag set.
- ACCESS: s_valid[sel] = 1 and a timeout counter increments.
  - s_ready[sel] = 1: capture s_rdata slot sel, go to RESP. s_ready of non-selected slaves is ignored.
  - Counter reaches TIMEOUT: go to RESP with error flag set; rdata = 0.
- RESP (one cycle): granted master's ready = 1 and its rdata = captured data. On error, rdata = 0 and bus_err = 1. s_valid = 0. Next state is GAP.
- GAP (one cycle): s_valid = 0. Slaves that echo ready one cycle after valid may still show ready here; it is ignored. Next state is IDLE.
- The non-granted master's ready stays 0 and its rdata is held.
- The arbitration pointer updates at grant.
- A master dropping valid mid-transaction does not abort it; the transaction still completes.

## Timing
- Reset values: all ready = 0, all rdata = 0, s_valid = 0, s_addr/s_wdata/s_wstrb = 0, bus_err = 0, state = IDLE, pointer favours m0. Reset mid-transaction aborts immediately with no ready pulse.
- All outputs are registered.
- Latency, zero-wait slave (ready one cycle after valid):
  - cycle 0: valid sampled in IDLE;
  - cycle 1: s_valid high;
  - cycle 2: s_ready high;
  - cycle 3: master ready high;
  - cycle 4: GAP;
  - cycle 5: IDLE, next grant possible.
- Decode miss: master ready and bus_err in cycle 1.
- Timeout: master ready in cycle TIMEOUT+2.
- Masters must deassert valid the cycle after seeing ready; a valid still high in IDLE starts a new transaction.
- Throughput: one transaction per 5 cycles with zero-wait slaves.

## Structure
- `periph_bus_pkg`:
  - state enum;
  - `ERR_RDATA` = 32'h0;
  - function computing the slot index width from NSLAVE.
- Sub-module `periph_addr_decode`: combinational; inputs addr, BASE, SLOT_BITS, NSLAVE; outputs hit and one-hot select.
- Round-robin and FSM stay in the top module.

## Test plan
- m0 reads slot 1 (addr 0x4000_0100), slave returns 0x0000_0001 with ready one cycle after valid → m0_ready high in cycle 3 with rdata 0x1; s_valid = 4'b0010 for exactly cycles 1–2.
- m1 writes 0x1 to 0x4000_0300 with wstrb 4'b0001 → s_wstrb, s_wdata and s_addr match; s_valid = 4'b1000; m1_ready pulses once; m0_ready stays 0.
- m0 and m1 both request continuously for four transactions → grants alternate m0, m1, m0, m1, with no gap shorter than GAP.
- Access to 0x5000_0000 → m0_ready and bus_err high in cycle 1, rdata = 0; s_valid never asserts.
- Slave holds ready low with TIMEOUT = 8 → ready and bus_err in cycle 10, rdata = 0; a subsequent access to another slot completes normally.
- resetn low during ACCESS → next cycle s_valid = 0 and no ready pulse; after release, the first simultaneous request goes to m0.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg
// Shared types and constants for the peripheral bus controller.
//   bus_state_t : controller FSM states (IDLE, ACCESS, RESP, GAP)
//   ERR_RDATA   : read data returned on decode miss or timeout
//   CNT_W       : width of the ACCESS timeout counter (TIMEOUT <= 65535)
//   slot_idx_w  : number of address bits needed to index NSLAVE slots
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_GAP    = 2'd3
  } bus_state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam int          CNT_W     = 16;

  function automatic int slot_idx_w(input int nslave);
    return (nslave > 1) ? $clog2(nslave) : 1;
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// periph_addr_decode
// Combinational address decoder for the peripheral window.
//   addr : byte address of the request
//   hit  : address lies inside the NSLAVE-slot window starting at BASE
//   sel  : one-hot slot select (all zero on a miss)
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int          NSLAVE    = 4,
  parameter logic [31:0] BASE      = 32'h4000_0000,
  parameter int          SLOT_BITS = 8
) (
  input  logic [31:0]       addr,
  output logic              hit,
  output logic [NSLAVE-1:0] sel
);

  localparam int IDX_W  = slot_idx_w(NSLAVE);
  localparam int TAG_LO = SLOT_BITS + IDX_W;

  logic [IDX_W-1:0] idx;
  logic             unused_low;

  // Everything above the slot index must match the window base.
  assign hit = (addr[31:TAG_LO] == BASE[31:TAG_LO]);
  assign idx = addr[SLOT_BITS +: IDX_W];

  // Offset within a slot is the slave's business, not the decoder's.
  assign unused_low = ^addr[SLOT_BITS-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVE; gi++) begin : g_sel
      assign sel[gi] = hit && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl
// Two-master, NSLAVE-slot controller for the memory-mapped peripheral bus.
// Round-robin arbitration between m0 (CPU) and m1 (debug/DMA), address
// decode to one slot, slave handshake with a one-cycle recovery gap, and
// error completion on decode miss or slave timeout.
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   mX_valid/mX_ready       master request / one-cycle completion pulse
//   mX_wstrb/addr/wdata     master request attributes (wstrb 0 = read)
//   mX_rdata                read data, valid while mX_ready is high
//   s_valid/s_ready         one-hot slave request / per-slave ready
//   s_wstrb/addr/wdata      shared slave request attributes
//   s_rdata                 slave k read data in bits [32k+31:32k]
//   bus_err                 one-cycle pulse on decode miss or timeout
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int          NSLAVE    = 4,
  parameter logic [31:0] BASE      = 32'h4000_0000,
  parameter int          SLOT_BITS = 8,
  parameter int          TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m0_valid,
  output logic                 m0_ready,
  input  logic [3:0]           m0_wstrb,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_valid,
  output logic                 m1_ready,
  input  logic [3:0]           m1_wstrb,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  output logic [31:0]          m1_rdata,
  output logic [NSLAVE-1:0]    s_valid,
  input  logic [NSLAVE-1:0]    s_ready,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  input  logic [32*NSLAVE-1:0] s_rdata,
  output logic                 bus_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  bus_state_t        state_reg, state_next;
  logic              gnt_m1_reg, gnt_m1_next;    // owner of the current transfer
  logic              prio_m1_reg, prio_m1_next;  // m1 wins the next tie
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [NSLAVE-1:0] s_valid_next;
  logic [3:0]        s_wstrb_next;
  logic [31:0]       s_addr_next, s_wdata_next;
  logic              m0_ready_next, m1_ready_next, bus_err_next;
  logic [31:0]       m0_rdata_next, m1_rdata_next;

  // Request selection and decode of the candidate address in IDLE.
  logic              pick_m1;
  logic [31:0]       req_addr;
  logic              dec_hit;
  logic [NSLAVE-1:0] dec_sel;

  assign pick_m1  = m1_valid && (!m0_valid || prio_m1_reg);
  assign req_addr = pick_m1 ? m1_addr : m0_addr;

  periph_addr_decode #(
    .NSLAVE    (NSLAVE),
    .BASE      (BASE),
    .SLOT_BITS (SLOT_BITS)
  ) u_decode (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // During ACCESS s_valid is the one-hot select, so it doubles as the mask
  // for ready and read data; other slaves' ready is ignored.
  logic [31:0] slot_word [NSLAVE];
  logic [31:0] slave_rdata;
  logic        slave_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVE; gi++) begin : g_rmux
      assign slot_word[gi] = s_rdata[32*gi +: 32] & {32{s_valid[gi]}};
    end
  endgenerate

  always_comb begin
    slave_rdata = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      slave_rdata = slave_rdata | slot_word[k];
    end
  end

  assign slave_ready = |(s_ready & s_valid);

  // Next-state and registered-output logic.
  logic        done;
  logic        done_err;
  logic [31:0] done_data;

  always_comb begin
    state_next    = state_reg;
    gnt_m1_next   = gnt_m1_reg;
    prio_m1_next  = prio_m1_reg;
    cnt_next      = cnt_reg;
    s_valid_next  = s_valid;
    s_wstrb_next  = s_wstrb;
    s_addr_next   = s_addr;
    s_wdata_next  = s_wdata;
    m0_ready_next = 1'b0;
    m1_ready_next = 1'b0;
    bus_err_next  = 1'b0;
    m0_rdata_next = m0_rdata;
    m1_rdata_next = m1_rdata;
    done          = 1'b0;
    done_err      = 1'b0;
    done_data     = ERR_RDATA;

    case (state_reg)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          gnt_m1_next  = pick_m1;
          prio_m1_next = !pick_m1;
          s_addr_next  = req_addr;
          s_wdata_next = pick_m1 ? m1_wdata : m0_wdata;
          s_wstrb_next = pick_m1 ? m1_wstrb : m0_wstrb;
          cnt_next     = '0;
          if (dec_hit) begin
            s_valid_next = dec_sel;
            state_next   = ST_ACCESS;
          end else begin
            done       = 1'b1;
            done_err   = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // A ready arriving on the last allowed cycle still wins.
        if (slave_ready) begin
          done         = 1'b1;
          done_data    = slave_rdata;
          s_valid_next = '0;
          state_next   = ST_RESP;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          done         = 1'b1;
          done_err     = 1'b1;
          s_valid_next = '0;
          state_next   = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Completion is registered, so the pulse appears in the RESP cycle.
    if (done) begin
      bus_err_next = done_err;
      if (gnt_m1_next) begin
        m1_ready_next = 1'b1;
        m1_rdata_next = done_data;
      end else begin
        m0_ready_next = 1'b1;
        m0_rdata_next = done_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      gnt_m1_reg  <= 1'b0;
      prio_m1_reg <= 1'b0;
      cnt_reg     <= '0;
      s_valid     <= '0;
      s_wstrb     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      bus_err     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_m1_reg  <= gnt_m1_next;
      prio_m1_reg <= prio_m1_next;
      cnt_reg     <= cnt_next;
      s_valid     <= s_valid_next;
      s_wstrb     <= s_wstrb_next;
      s_addr      <= s_addr_next;
      s_wdata     <= s_wdata_next;
      m0_ready    <= m0_ready_next;
      m1_ready    <= m1_ready_next;
      m0_rdata    <= m0_rdata_next;
      m1_rdata    <= m1_rdata_next;
      bus_err     <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl
// Self-checking bench for periph_bus_ctrl (NSLAVE=4, TIMEOUT=8): a table of
// directed transactions, hand-written reset and arbitration sequences, and
// randomized single-master transactions checked against a reference model.
module tb_periph_bus_ctrl;

  localparam int          NSL    = 4;
  localparam logic [31:0] BASE_A = 32'h4000_0000;
  localparam int          TO     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]       m0_wstrb, m1_wstrb;
  logic [31:0]      m0_addr, m0_wdata, m0_rdata;
  logic [31:0]      m1_addr, m1_wdata, m1_rdata;
  logic [NSL-1:0]   s_valid, s_ready;
  logic [3:0]       s_wstrb;
  logic [31:0]      s_addr, s_wdata;
  logic [32*NSL-1:0] s_rdata;
  logic             bus_err;

  int n_vec = 0;
  int n_bad = 0;

  periph_bus_ctrl #(
    .NSLAVE    (NSL),
    .BASE      (BASE_A),
    .SLOT_BITS (8),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_wstrb (m0_wstrb),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_wstrb (m1_wstrb),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_wstrb  (s_wstrb),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .bus_err  (bus_err)
  );

  // Slave models: ready rises lat cycles after the first cycle ready could
  // follow valid (lat=0 is a zero-wait slave). noise_mask forces ready on
  // slaves that are not addressed.
  logic [NSL-1:0] mdl_ready  = '0;
  logic [NSL-1:0] noise_mask = '0;
  int             slv_wait [NSL] = '{default: 0};
  int             slv_lat  [NSL] = '{default: 0};
  logic [31:0]    slv_data [NSL] = '{default: 32'h0};

  assign s_ready = mdl_ready | noise_mask;

  always_comb begin
    s_rdata = '0;
    for (int k = 0; k < NSL; k++) s_rdata[32*k +: 32] = slv_data[k];
  end

  always @(posedge clk) begin
    for (int k = 0; k < NSL; k++) begin
      if (s_valid[k]) begin
        mdl_ready[k] <= (slv_wait[k] >= slv_lat[k]);
        slv_wait[k]  <= slv_wait[k] + 1;
      end else begin
        mdl_ready[k] <= 1'b0;
        slv_wait[k]  <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg_slaves(input logic [31:0] addr, input int lat,
                            input logic [31:0] sdata, input bit noise);
    int slot;
    slot = int'(addr[9:8]);
    for (int k = 0; k < NSL; k++) begin
      slv_lat[k]  = lat;
      slv_data[k] = (k == slot) ? sdata : (~sdata ^ 32'(k + 1));
    end
    noise_mask = noise ? ~(4'b0001 << slot) : 4'b0000;
  endtask

  // Reference model: timing and result of a lone transaction, counted from
  // the cycle in which valid is sampled in IDLE.
  function automatic void ref_txn(input logic [31:0] addr, input int lat,
                                  input logic [31:0] sdata, output int cyc,
                                  output bit err, output logic [31:0] rd,
                                  output logic [3:0] sel);
    longint a, lo, hi;
    int     slot;
    a  = longint'(addr);
    lo = longint'(BASE_A);
    hi = lo + NSL * 256;
    if (a < lo || a >= hi) begin
      cyc = 1; err = 1'b1; rd = 32'h0; sel = 4'b0000;
    end else begin
      slot = int'((a - lo) / 256);
      sel  = 4'(1 << slot);
      if (lat < TO) begin
        cyc = lat + 3; err = 1'b0; rd = sdata;
      end else begin
        cyc = TO + 2; err = 1'b1; rd = 32'h0;
      end
    end
  endfunction

  // Issues one transaction from master m starting at a negedge in IDLE,
  // observes it through GAP and returns at the negedge of the next IDLE cycle.
  task automatic run_check(input string nm, input bit m, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata,
                           input int exp_cyc, input bit exp_err,
                           input logic [31:0] exp_rd, input logic [3:0] exp_sel);
    int          cyc, err_cnt, sv_cnt, pulses, other, attr_bad;
    logic [31:0] rd;
    logic [3:0]  seen;
    cyc = 0; err_cnt = 0; sv_cnt = 0; pulses = 0; other = 0; attr_bad = 0;
    rd = 32'h0; seen = 4'b0000;
    if (m) begin
      m1_addr = addr; m1_wstrb = wstrb; m1_wdata = wdata; m1_valid = 1'b1;
    end else begin
      m0_addr = addr; m0_wstrb = wstrb; m0_wdata = wdata; m0_valid = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (s_valid != 4'b0000) begin
        sv_cnt++;
        seen = seen | s_valid;
        if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb) attr_bad++;
      end
      if (bus_err) err_cnt++;
      if (m ? m1_ready : m0_ready) begin
        pulses++;
        if (cyc == 0) begin
          cyc = c;
          rd  = m ? m1_rdata : m0_rdata;
          m0_valid = 1'b0;
          m1_valid = 1'b0;
        end
      end
      if (m ? m0_ready : m1_ready) other++;
      if (cyc != 0 && c == cyc + 2) break;
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk({nm, "_ready_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_bus_err"}, 32'(err_cnt), exp_err ? 32'd1 : 32'd0);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_s_valid_sel"}, 32'(seen), 32'(exp_sel));
    chk({nm, "_s_valid_cycles"}, 32'(sv_cnt), (exp_sel != 0) ? 32'(exp_cyc - 1) : 32'd0);
    chk({nm, "_ready_pulses"}, 32'(pulses), 32'd1);
    chk({nm, "_other_ready"}, 32'(other), 32'd0);
    chk({nm, "_slave_attrs"}, 32'(attr_bad), 32'd0);
    $display("txn %s m%0d addr=%h wstrb=%h cyc=%0d err=%0d rdata=%h",
             nm, m, addr, wstrb, cyc, err_cnt, rd);
  endtask

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
    bit          noise;
    logic [31:0] sdata;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, got, t_prev, who;
    bit          err;
    logic [31:0] rd, addr, sdata;
    logic [3:0]  sel;
    int          lat;
    bit          m, noise;

    //           m  addr          wstrb    wdata          lat  nz sdata          cyc err rdata          sel
    tbl[0] = '{1'b0, 32'h4000_0100, 4'b0000, 32'h0,          0, 1'b0, 32'h0000_0001,  3, 1'b0, 32'h0000_0001, 4'b0010};
    tbl[1] = '{1'b1, 32'h4000_0300, 4'b0001, 32'h0000_0001,  0, 1'b0, 32'h0BAD_F00D,  3, 1'b0, 32'h0BAD_F00D, 4'b1000};
    tbl[2] = '{1'b0, 32'h5000_0000, 4'b0000, 32'h0,          0, 1'b0, 32'h0000_1234,  1, 1'b1, 32'h0,         4'b0000};
    tbl[3] = '{1'b0, 32'h4000_0200, 4'b0000, 32'h0,        255, 1'b1, 32'h0000_CAFE, 10, 1'b1, 32'h0,         4'b0100};
    tbl[4] = '{1'b1, 32'h4000_0004, 4'b1111, 32'hFFFF_0000,  0, 1'b1, 32'hA5A5_5A5A,  3, 1'b0, 32'hA5A5_5A5A, 4'b0001};
    tbl[5] = '{1'b0, 32'h4000_03FC, 4'b0110, 32'h1357_9BDF,  7, 1'b0, 32'h7777_0007, 10, 1'b0, 32'h7777_0007, 4'b1000};
    tbl[6] = '{1'b1, 32'h4000_0180, 4'b0000, 32'h0,          8, 1'b0, 32'h0000_8888, 10, 1'b1, 32'h0,         4'b0010};
    tbl[7] = '{1'b0, 32'h3FFF_FFFC, 4'b1111, 32'h0000_0001,  0, 1'b0, 32'h0000_0001,  1, 1'b1, 32'h0,         4'b0000};
    tbl[8] = '{1'b1, 32'h4000_0400, 4'b0000, 32'h0,          0, 1'b0, 32'h0000_0001,  1, 1'b1, 32'h0,         4'b0000};
    tbl[9] = '{1'b0, 32'h4000_00FF, 4'b0000, 32'h0,          2, 1'b0, 32'hDEAD_BEEF,  5, 1'b0, 32'hDEAD_BEEF, 4'b0001};

    resetn   = 1'b0;
    m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_attrs", s_addr | s_wdata | 32'(s_wstrb), 32'd0);
    chk("rst_ready_err", {29'd0, m0_ready, m1_ready, bus_err}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      cfg_slaves(tbl[i].addr, tbl[i].lat, tbl[i].sdata, tbl[i].noise);
      run_check($sformatf("tbl%0d", i), tbl[i].m, tbl[i].addr, tbl[i].wstrb,
                tbl[i].wdata, tbl[i].exp_cyc, tbl[i].exp_err, tbl[i].exp_rd,
                tbl[i].exp_sel);
    end

    // Reset during ACCESS aborts without a ready pulse.
    cfg_slaves(32'h4000_0200, 255, 32'h0000_2222, 1'b0);
    m1_addr = 32'h4000_0200; m1_wstrb = 4'h0; m1_wdata = 32'h0; m1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_s_valid_before", 32'(s_valid), 32'h4);
    resetn   = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_s_valid_after", 32'(s_valid), 32'd0);
    got = 0;
    for (int c = 0; c < 3; c++) begin
      if (m0_ready || m1_ready || bus_err) got++;
      @(negedge clk);
    end
    chk("rstmid_no_ready", 32'(got), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    $display("txn rstmid reset applied during ACCESS");

    // Both masters request continuously: m0 first after reset, then alternate.
    for (int k = 0; k < NSL; k++) slv_lat[k] = 0;
    slv_data[0] = 32'h0000_00A0; slv_data[1] = 32'h0000_00B1;
    slv_data[2] = 32'h0000_00C2; slv_data[3] = 32'h0000_00D3;
    noise_mask = '0;
    m0_addr = 32'h4000_0000; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    m1_addr = 32'h4000_0100; m1_wstrb = 4'h0; m1_wdata = 32'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    got = 0; t_prev = 0;
    for (int c = 1; c <= 60 && got < 4; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        who = m1_ready ? 1 : 0;
        chk($sformatf("arb_grant%0d", got), 32'(who), 32'(got % 2));
        chk($sformatf("arb_rdata%0d", got), who ? m1_rdata : m0_rdata,
            who ? 32'h0000_00B1 : 32'h0000_00A0);
        if (got == 0) chk("arb_first_cycle", 32'(c), 32'd3);
        else          chk($sformatf("arb_spacing%0d", got), 32'(c - t_prev), 32'd5);
        $display("txn arb%0d m%0d cyc=%0d", got, who, c);
        t_prev = c;
        got++;
        if (got == 4) begin
          m0_valid = 1'b0;
          m1_valid = 1'b0;
        end
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    chk("arb_count", 32'(got), 32'd4);
    @(negedge clk);
    @(negedge clk);

    // Randomized single-master transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) addr = BASE_A + 32'($urandom_range(0, 255) << 2);
      else                           addr = $urandom;
      lat   = int'($urandom_range(0, 10));
      sdata = $urandom;
      noise = 1'($urandom_range(0, 1));
      ref_txn(addr, lat, sdata, cyc, err, rd, sel);
      cfg_slaves(addr, lat, sdata, noise);
      run_check($sformatf("rnd%0d", i), m, addr, 4'($urandom_range(0, 15)),
                $urandom, cyc, err, rd, sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
